// File: rtl/axi4_slave_mem_if.sv
// AXI4 bus bundle between a master and the axi4_slave_mem responder.
// Every channel transfers on the rising clock edge where valid and ready are both high; a source
// holds valid and its payload unchanged until that edge, and ready may change freely while valid is low.
interface axi4_slave_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 responder over a word-addressed memory: independent write and read engines,
// one outstanding burst per direction, FIXED/INCR/WRAP addressing, SLVERR on illegal bursts.
module axi4_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic             aclk,
  input  logic             arst,
  axi4_slave_mem_if.slave  s_axi,
  output logic [1:0]       o_dbg_w_state,
  output logic             o_dbg_r_state
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OB         = $clog2(STRB_WIDTH);
  localparam int IW         = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [7:0] len,
                                                        input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] inc;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << OB) - ADDR_WIDTH'(1);
    inc  = a + ADDR_WIDTH'(STRB_WIDTH);
    case (burst)
      2'b00:   f_next_addr = a;
      2'b10:   f_next_addr = (a & ~mask) | (inc & mask);
      default: f_next_addr = inc;
    endcase
  endfunction

  function automatic logic f_illegal(input logic [1:0] burst, input logic [7:0] len);
    f_illegal = (burst == 2'b11) ||
                ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) ||
                                       (len == 8'd7) || (len == 8'd15)));
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // ---------------- write engine ----------------
  w_state_t              r_w_state, w_w_next;
  logic [ID_WIDTH-1:0]   r_bid;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_wlen, r_wcnt;
  logic [1:0]            r_wburst;
  logic                  r_wskip, r_werr;
  logic                  w_awready, w_wready, w_bvalid;
  logic                  w_aw_hs, w_w_hs;
  logic [IW-1:0]         w_widx;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) r_w_state <= W_IDLE;
    else      r_w_state <= w_w_next;
  end

  always_comb begin
    w_w_next  = r_w_state;
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_bvalid  = 1'b0;
    case (r_w_state)
      W_IDLE: begin
        w_awready = 1'b1;
        if (s_axi.awvalid) w_w_next = W_DATA;
      end
      W_DATA: begin
        w_wready = 1'b1;
        if (s_axi.wvalid && (r_wcnt == 8'd0)) w_w_next = W_RESP;
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (s_axi.bready) w_w_next = W_IDLE;
      end
      default: w_w_next = W_IDLE;
    endcase
  end

  assign w_aw_hs = s_axi.awvalid && w_awready;
  assign w_w_hs  = s_axi.wvalid && w_wready;
  assign w_widx  = r_waddr[OB +: IW];

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_bid    <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wburst <= '0;
      r_wskip  <= 1'b0;
      r_werr   <= 1'b0;
    end else if (w_aw_hs) begin
      r_bid    <= s_axi.awid;
      r_waddr  <= s_axi.awaddr;
      r_wlen   <= s_axi.awlen;
      r_wcnt   <= s_axi.awlen;
      r_wburst <= s_axi.awburst;
      r_wskip  <= f_illegal(s_axi.awburst, s_axi.awlen);
      r_werr   <= f_illegal(s_axi.awburst, s_axi.awlen);
    end else if (w_w_hs) begin
      r_waddr <= f_next_addr(r_waddr, r_wlen, r_wburst);
      r_wcnt  <= r_wcnt - 8'd1;
      // A misplaced wlast is reported but never shortens or extends the burst.
      if (s_axi.wlast != (r_wcnt == 8'd0)) r_werr <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_w_hs && !r_wskip) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi.wstrb[b]) r_mem[w_widx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  assign s_axi.awready = w_awready;
  assign s_axi.wready  = w_wready;
  assign s_axi.bvalid  = w_bvalid;
  assign s_axi.bid     = r_bid;
  assign s_axi.bresp   = r_werr ? 2'b10 : 2'b00;

  // ---------------- read engine ----------------
  r_state_t              r_r_state, w_r_next;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]            r_rlen, r_rcnt;
  logic [1:0]            r_rburst;
  logic                  r_rerr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_arready, w_rvalid;
  logic                  w_ar_hs, w_r_hs;
  logic [ADDR_WIDTH-1:0] w_r_nxt;
  logic [IW-1:0]         w_ridx;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) r_r_state <= R_IDLE;
    else      r_r_state <= w_r_next;
  end

  always_comb begin
    w_r_next  = r_r_state;
    w_arready = 1'b0;
    w_rvalid  = 1'b0;
    case (r_r_state)
      R_IDLE: begin
        w_arready = 1'b1;
        if (s_axi.arvalid) w_r_next = R_DATA;
      end
      R_DATA: begin
        w_rvalid = 1'b1;
        if (s_axi.rready && (r_rcnt == 8'd0)) w_r_next = R_IDLE;
      end
      default: w_r_next = R_IDLE;
    endcase
  end

  assign w_ar_hs = s_axi.arvalid && w_arready;
  assign w_r_hs  = s_axi.rready && w_rvalid;
  assign w_r_nxt = f_next_addr(r_raddr, r_rlen, r_rburst);
  // The memory is read one beat ahead so accepted beats can stream every cycle.
  assign w_ridx  = w_ar_hs ? s_axi.araddr[OB +: IW] : w_r_nxt[OB +: IW];

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rburst <= '0;
      r_rerr   <= 1'b0;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rid    <= s_axi.arid;
      r_raddr  <= s_axi.araddr;
      r_rlen   <= s_axi.arlen;
      r_rcnt   <= s_axi.arlen;
      r_rburst <= s_axi.arburst;
      r_rerr   <= f_illegal(s_axi.arburst, s_axi.arlen);
      r_rdata  <= f_illegal(s_axi.arburst, s_axi.arlen) ? '0 : r_mem[w_ridx];
    end else if (w_r_hs && (r_rcnt != 8'd0)) begin
      r_raddr <= w_r_nxt;
      r_rcnt  <= r_rcnt - 8'd1;
      r_rdata <= r_rerr ? '0 : r_mem[w_ridx];
    end
  end

  assign s_axi.arready = w_arready;
  assign s_axi.rvalid  = w_rvalid;
  assign s_axi.rid     = r_rid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rerr ? 2'b10 : 2'b00;
  assign s_axi.rlast   = w_rvalid && (r_rcnt == 8'd0);

  assign o_dbg_w_state = r_w_state;
  assign o_dbg_r_state = r_r_state;
endmodule

// File: doc/axi4_slave_mem.md
Name:
axi4_slave_mem

Overview:
AXI4 responder (slave) backed by an internal word-addressed memory. It is the target end of the AXI4 bus that the bridge and the master VIP drive, and it serves as the default DUT-side memory model and synthesizable test target. It runs independent write and read engines, with one outstanding transaction per direction and no interleaving.

Parameters:
DATA_WIDTH, 32, data bus width in bits; STRB_WIDTH = DATA_WIDTH/8; byte offset width OB = log2(STRB_WIDTH)
ADDR_WIDTH, 16, byte address width
ID_WIDTH, 8, AXI ID width
MEM_DEPTH, 1024, number of DATA_WIDTH words; power of 2

Ports:
aclk  in  1  clock
arst  in  1  reset, asynchronous, active-high
awid  in  ID_WIDTH  write ID
awaddr  in  ADDR_WIDTH  write byte address
awlen  in  8  beats-1
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  DATA_WIDTH  write data
wstrb  in  STRB_WIDTH  byte enables
wlast  in  1  master's last-beat flag
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_WIDTH  response ID (= latched awid)
bresp  out  2  00 OKAY, 10 SLVERR
bvalid  out  1  B valid
bready  in  1  B ready
arid  in  ID_WIDTH  read ID
araddr  in  ADDR_WIDTH  read byte address
arlen  in  8  beats-1
arburst  in  2  burst type
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  ID_WIDTH  read ID (= latched arid)
rdata  out  DATA_WIDTH  read data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final beat
rvalid  out  1  R valid
rready  in  1  R ready

Behaviour:
- Reset (async, any time, including mid-burst): awready=1, arready=1; wready, bvalid, rvalid, rlast=0; bid, bresp, rid, rresp, rdata=0; both FSMs return to IDLE. Memory contents are not cleared; beats already written remain. Every beat is full width and AxSIZE/LOCK/CACHE/PROT are not connected. Word index = addr[OB +: log2(MEM_DEPTH)]; upper address bits alias.
- Address step (bytes B=STRB_WIDTH): FIXED holds the address. INCR adds B, wrapping modulo 2^ADDR_WIDTH. WRAP uses mask=(len+1)*B-1 and next=(addr & ~mask)|((addr+B) & mask).
- Illegal burst: burst=11, or WRAP with len not in {1,3,7,15}. The transaction still completes with the correct beat count, performs no memory writes, and uses SLVERR; read data for it is 0.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On awvalid&awready, latch id/addr/len/burst and set the beat counter to len. In the next cycle awready=0 and wready=1.
  - W_DATA: on each wvalid&wready, write the bytes enabled by wstrb, advance the address, and decrement the counter.
  - On the beat with counter==0, wready drops next cycle and bvalid=1. wlast must equal (counter==0) on every beat; any mismatch latches SLVERR. Termination is governed by the counter only.
  - W_RESP: bid/bresp/bvalid are held until bready. awready=1 in the cycle after the B handshake.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On the AR handshake, latch the fields and register mem[araddr] into rdata. rvalid=1 and arready=0 in the next cycle.
  - rlast=1 exactly when the remaining count is 0.
  - On rvalid&rready with beats remaining, load the next address's word; this allows back-to-back beats every cycle while rready=1.
  - rid/rdata/rresp/rlast are stable while rvalid&!rready.
  - After the last beat is accepted: rvalid=0 and arready=1 next cycle.
- Simultaneous write and read of the same word in one cycle: the read returns the old data. The two engines never stall each other.

Test Plan:
- Write 0x0010 len0 INCR awid=0x5A, data 0xDEADBEEF, wstrb F; then read 0x0010 with arid=0x3C -> bid=0x5A, bresp=00; rdata=0xDEADBEEF, rid=0x3C, rresp=00, rlast=1, rvalid one cycle after the AR handshake.
- INCR len3 @0x0100, data 1,2,3,4; read back with rready toggling 1,0,1,0 -> beats 1,2,3,4 in order; rlast only on 4; rdata stable during stalls.
- WRAP len3 @0x0108, data A,B,C,D; INCR read len3 @0x0100 -> C,D,A,B.
- Write 0xFFFFFFFF @0x20, then wstrb=0101 data 0x11223344 -> read returns 0xFF22FF44.
- Write len3 with wlast on beat 1 -> 4 beats accepted, bresp=10; read burst=11 len1 -> 2 beats with rresp=10, rdata=0, rlast on beat 2; no memory change.
- Assert arst after beat 2 of a len7 read -> rvalid=0 and arready=1 immediately; the next read of 0x0010 returns 0xDEADBEEF.
